fft_stage_sequencer: RTL and testbench

Control block that runs a radix-2 decimation-in-time FFT in place on the dual-port working RAM (`fft_working_ram`, 1-cycle registered read). For every stage and butterfly it drives both RAM ports with the read addresses and the twiddle ROM address. After the butterfly pipeline latency it drives the same ports with the write-back addresses. Reads and writes share the two ports on alternating cycles. The block sits between the top-level FFT control (start/done) and the RAM/butterfly datapath. The input buffer must already hold its samples in bit-reversed order.

---
 rtl/fft_stage_sequencer.sv | 117 +++++++++++
 tb/tb_fft_stage_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: in-place radix-2 DIT FFT address/twiddle sequencer with delayed write-back.
// Optional macro FFT_SEQ_STAGE_SCALE_EN enables the per-butterfly o_scale request.
module fft_stage_sequencer #(
  parameter int N_POINTS   = 512,
  parameter int BF_LATENCY = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(N_POINTS)-1:0]   o_addr_a,
  output logic [$clog2(N_POINTS)-1:0]   o_addr_b,
  output logic                          o_wr_en,
  output logic                          o_rd_issue,
  output logic [$clog2(N_POINTS)-2:0]   o_twiddle_addr,
  output logic [$clog2(N_POINTS)-1:0]   o_stage,
  output logic                          o_scale
);
  localparam int AW = $clog2(N_POINTS);
  localparam int TW = AW - 1;
  localparam int L  = BF_LATENCY;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] stage_q, stage_d, j_q, j_d, rd_s, rd_j;
  logic [AW-1:0] a_q, a_d, b_q, b_d, mask, pos, ra, rb, tsh;
  logic [TW-1:0] tw_q, tw_d, rtw;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [L-1:0] dv_q;
  logic [L-1:0][AW-1:0] da_q, db_q;
  always_comb begin
    state_d = state_q;
    rd_s    = stage_q;
    rd_j    = j_q;
    rd_d    = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = RUN;
        rd_d    = 1'b1;
        rd_s    = '0;
        rd_j    = '0;
      end
      RUN: begin
        if (rd_q && j_q == AW'(N_POINTS / 2)) state_d = DRAIN;
        else rd_d = ~rd_q;
      end
      // The delay line is empty exactly in the cycle the last write of the stage is driven
      DRAIN: if (dv_q == '0) begin
        if (stage_q == AW'(AW - 1)) state_d = DONE;
        else begin
          state_d = RUN;
          rd_d    = 1'b1;
          rd_s    = stage_q + AW'(1);
          rd_j    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    stage_d = rd_d ? rd_s : stage_q;
    j_d     = rd_d ? rd_j + AW'(1) : j_q;
    mask    = (AW'(1) << rd_s) - AW'(1);
    pos     = rd_j & mask;
    ra      = ((rd_j >> rd_s) << (rd_s + AW'(1))) | pos;
    rb      = ra + mask + AW'(1);
    tsh     = AW'(AW - 1) - rd_s;
    rtw     = TW'(pos << tsh);
    wr_d    = dv_q[L-1];
    a_d     = rd_d ? ra : wr_d ? da_q[L-1] : a_q;
    b_d     = rd_d ? rb : wr_d ? db_q[L-1] : b_q;
    tw_d    = rd_d ? rtw : tw_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dv_q    <= '0;
      da_q    <= '0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dv_q    <= {dv_q[L-2:0], rd_d};
      da_q    <= {da_q[L-2:0], ra};
      db_q    <= {db_q[L-2:0], rb};
    end
  end
  assign o_busy         = state_q != IDLE;
  assign o_done         = state_q == DONE;
  assign o_addr_a       = a_q;
  assign o_addr_b       = b_q;
  assign o_wr_en        = wr_q;
  assign o_rd_issue     = rd_q;
  assign o_twiddle_addr = tw_q;
  assign o_stage        = stage_q;
`ifdef FFT_SEQ_STAGE_SCALE_EN
  logic scale_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scale_q <= 1'b0;
    else scale_q <= rd_d;
  end
  assign o_scale = scale_q;
`else
  assign o_scale = 1'b0;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: N=8, BF_LATENCY=3 bench against a per-cycle timeline built from the addressing rules.
module tb_fft_stage_sequencer;
  localparam int N = 8, L = 3, S = 3, AW = 3;
  localparam int TOT = S * (N - 1 + L);
`ifdef FFT_SEQ_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic o_busy, o_done, o_wr_en, o_rd_issue, o_scale;
  logic [AW-1:0] o_addr_a, o_addr_b, o_stage;
  logic [AW-2:0] o_twiddle_addr;
  fft_stage_sequencer #(.N_POINTS(N), .BF_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_addr_a(o_addr_a), .o_addr_b(o_addr_b), .o_wr_en(o_wr_en), .o_rd_issue(o_rd_issue),
    .o_twiddle_addr(o_twiddle_addr), .o_stage(o_stage), .o_scale(o_scale)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  typedef struct {int s; int a; int b; int tw;} rd_t;
  rd_t tbl[12];
  rd_t got[$];
  int e_rd[TOT+2], e_wr[TOT+2], e_a[TOT+2], e_b[TOT+2], e_tw[TOT+2], e_st[TOT+2];
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic void build();
    int j, c, half;
    for (int k = 0; k < TOT + 2; k++) begin
      e_rd[k] = 0; e_wr[k] = 0; e_a[k] = -1; e_b[k] = -1; e_tw[k] = 0; e_st[k] = 0;
    end
    for (int s = 0; s < S; s++) begin
      half = 1 << s;
      j = 0;
      for (int g = 0; g < N / (2 * half); g++)
        for (int p = 0; p < half; p++) begin
          c = s * (N - 1 + L) + 2 * j;
          e_rd[c] = 1; e_a[c] = g * 2 * half + p; e_b[c] = e_a[c] + half;
          e_tw[c] = p * (N / (2 * half)); e_st[c] = s;
          e_wr[c+L] = 1; e_a[c+L] = e_a[c]; e_b[c+L] = e_b[c];
          j++;
        end
    end
    for (int k = 1; k < TOT + 2; k++)
      if (e_a[k] < 0) begin
        e_a[k] = e_a[k-1]; e_b[k] = e_b[k-1];
      end
  endfunction
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, o_busy, 0);
    chk({n, "_done"}, o_done, 0);
    chk({n, "_wr"}, o_wr_en, 0);
    chk({n, "_rd"}, o_rd_issue, 0);
    chk({n, "_scale"}, o_scale, 0);
    chk({n, "_a"}, o_addr_a, 0);
    chk({n, "_b"}, o_addr_b, 0);
    chk({n, "_tw"}, o_twiddle_addr, 0);
    chk({n, "_stage"}, o_stage, 0);
  endtask
  task automatic run(input bit hold, input int abort_at);
    got.delete();
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk); #1 i_start = 1'b1;
    @(negedge clk);
    chk("pre_busy", o_busy, 0);
    @(posedge clk); #1 i_start = hold ? 1'b1 : 1'($urandom % 2);
    for (int c = 0; c <= TOT + 2; c++) begin
      @(negedge clk);
      if (c == TOT + 2) begin
        chk("no_restart_rd", o_rd_issue, 0);
        chk("no_restart_busy", o_busy, 0);
      end else begin
        chk("rd", o_rd_issue, e_rd[c]);
        chk("wr", o_wr_en, e_wr[c]);
        chk("excl", int'(o_rd_issue & o_wr_en), 0);
        chk("addr_a", o_addr_a, e_a[c]);
        chk("addr_b", o_addr_b, e_b[c]);
        chk("done", o_done, int'(c == TOT));
        chk("busy", o_busy, int'(c <= TOT));
        chk("scale", o_scale, SCALE ? e_rd[c] : 0);
        if (e_rd[c] != 0) begin
          chk("twiddle", o_twiddle_addr, e_tw[c]);
          chk("stage", o_stage, e_st[c]);
        end
      end
      if (o_rd_issue) got.push_back('{int'(o_stage), int'(o_addr_a), int'(o_addr_b), int'(o_twiddle_addr)});
      i_start = (c < TOT) ? (hold ? 1'b1 : 1'($urandom % 2)) : 1'b0;
      if (c == abort_at) begin
        i_start = 1'b0;
        rst = 1'b1;
        #1 chk_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          chk("post_rst_wr", o_wr_en, 0);
          chk("post_rst_busy", o_busy, 0);
        end
        return;
      end
    end
    chk("nreads", got.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got.size()) begin
        chk("tbl_stage", got[i].s, tbl[i].s);
        chk("tbl_a", got[i].a, tbl[i].a);
        chk("tbl_b", got[i].b, tbl[i].b);
        chk("tbl_tw", got[i].tw, tbl[i].tw);
      end
  endtask
  initial begin
    tbl = '{'{0,0,1,0}, '{0,2,3,0}, '{0,4,5,0}, '{0,6,7,0},
            '{1,0,2,0}, '{1,1,3,2}, '{1,4,6,0}, '{1,5,7,2},
            '{2,0,4,0}, '{2,1,5,1}, '{2,2,6,2}, '{2,3,7,3}};
    build();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    run(1'b0, -1);
    run(1'b1, -1);
    run(1'b0, $urandom_range(N - 1 + L, 2 * (N - 1 + L) - 1));
    run(1'b0, -1);
    repeat (2) run(1'($urandom % 2), -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
